ram_2r_2w_access_ctrl: RTL and testbench
========================================

// Module: ram_2r_2w_access_ctrl
// PURPOSE
//  Requester-side controller for a DW_ram_2r_2w_s_dff register-file RAM.
//  - Converts two write and two read valid/ready request channels into the RAM's active-low enables, addresses and data.
//  - Registers read data into per-port response channels.
//  - After reset, clears every RAM word to zero before accepting traffic.
//  - Sits between pipeline clients and one RAM instance. The RAM is instantiated inside this block.
// PARAMETERS
//  WIDTH       8   data word width, bits
//  ADDR_WIDTH  3   address width; DEPTH = 2**ADDR_WIDTH (>=2)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           asynchronous active-high reset
//  init_done    out  1           high once RAM clear finished
//  w1_valid     in   1           write ch1 request
//  w1_ready     out  1           write ch1 accept
//  w1_addr      in   ADDR_WIDTH  write ch1 address
//  w1_data      in   WIDTH       write ch1 data
//  w2_valid/w2_ready/w2_addr/w2_data                write ch2, same as ch1
//  r1_req_valid in   1           read ch1 request
//  r1_req_ready out  1           read ch1 accept
//  r1_req_addr  in   ADDR_WIDTH  read ch1 address
//  r1_rsp_valid out  1           read ch1 data valid
//  r1_rsp_ready in   1           read ch1 data taken
//  r1_rsp_data  out  WIDTH       read ch1 data
//  r2_*         same set as r1_*                     read ch2
// BEHAVIOUR
//  Reset (async, rst=1): init_done=0, all *_ready=0, r*_rsp_valid=0, r*_rsp_data=0, FSM=INIT, init pointer=0.
//    The RAM rst_n is tied to ~rst (rst_mode=0).
//    Reset mid-operation aborts everything; in-flight responses are lost; INIT restarts.
//  FSM states INIT, RUN.
//    INIT: each cycle writes 0 to addr ptr via port 1 and ptr+1 via port 2; ptr += 2.
//      After writing DEPTH-2..DEPTH-1, go to RUN.
//      INIT lasts DEPTH/2 cycles; no ready asserted.
//    RUN: permanent until reset; init_done=1.
//  Write handshake: a transfer occurs on valid&ready. The RAM write lands at that clk edge.
//    w1_ready = RUN.
//    w2_ready = RUN & ~(w1_valid & w2_valid & w1_addr==w2_addr).
//    On a same-address collision only w1 is written that cycle; w2 stalls one cycle, so w2's data wins.
//  Read handshake: rN_req_ready = RUN & (~rN_rsp_valid | rN_rsp_ready).
//    On accept, the RAM asynchronous read output is captured into rN_rsp_data at the edge; rN_rsp_valid=1 the next cycle (latency 1).
//    The response holds stable while rN_rsp_valid & ~rN_rsp_ready.
//    A response popped with no new accept clears valid; data holds its last value.
//  Read/write ordering: a read accepted in the same cycle as a write to the same address returns the OLD data (read-before-write).
//    A read accepted the cycle after returns the new data.
//  Read ports are independent; both may read the same address simultaneously.
//  RAM enables are active-low: en_wN_n = ~(wN transfer | INIT), en_rN_n = ~(rN accept).
//  Ready signals are combinational from valid/addr/state. No valid->ready dependency on the read side.
//  Reading an unwritten address after INIT returns 0.
// STRUCTURE
//  Package ram_2r_2w_ctrl_pkg holds:
//    - state typedef {INIT, RUN}
//    - function addr_eq collision check
//  Sub-module ram_2r_2w_rsp_reg (one per read port): 1-entry valid/ready holding register, instantiated twice.
//  The DW_ram_2r_2w_s_dff instance is in the top level.
//  Target 150-250 lines of RTL total.
// TESTING
//  1. Reset release, ADDR_WIDTH=3 -> init_done rises after exactly 4 clk; reading all 8 addrs returns 0x00.
//  2. w1 addr3=0xA5, next cycle r1 addr3 -> r1_rsp_valid 1 cycle after accept, data 0xA5.
//  3. Same-cycle w1 addr5=0x11, w2 addr5=0x22 -> w2_ready=0 in that cycle, w2 accepted next cycle; later read addr5=0x22.
//  4. Read addr2 (holding 0x00) in the same cycle as write addr2=0x7E -> rsp 0x00; read on next cycle -> 0x7E.
//  5. r2_rsp_ready=0 for 5 cycles with a pending response -> r2_rsp_data stable, r2_req_ready=0; r1 traffic unaffected.
//  6. Assert rst mid-traffic with rsp_valid=1 -> rsp_valid drops immediately (async), INIT reruns, and all words read back 0.

Source files
------------

// File: rtl/ram_2r_2w_ctrl_pkg.sv
// Shared types and helpers for the 2-read/2-write RAM access controller.
//   ctrl_state_t : controller state (INIT clears the RAM, RUN serves traffic)
//   addr_eq      : address comparison used for write-port collision detection
package ram_2r_2w_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // Widest address the collision helper compares; callers zero-extend into it.
    localparam int ADDR_CMP_W = 16;

    function automatic logic addr_eq(input logic [ADDR_CMP_W-1:0] a,
                                     input logic [ADDR_CMP_W-1:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/DW_ram_2r_2w_s_dff.sv
// Behavioural model of the 2-read/2-write flip-flop register file.
// Writes are synchronous with active-low enables (port 2 wins on a same-address
// write); reads are asynchronous and return zero while their enable is inactive.
// rst_mode 0 clears the array asynchronously on rst_n, otherwise synchronously.
// Ports: clk, rst_n, en_w1_n/addr_w1/data_w1, en_w2_n/addr_w2/data_w2,
//        en_r1_n/addr_r1/data_r1, en_r2_n/addr_r2/data_r2.
module DW_ram_2r_2w_s_dff #(
    parameter int width      = 8,
    parameter int addr_width = 3,
    parameter int rst_mode   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_w1_n,
    input  logic [addr_width-1:0] addr_w1,
    input  logic [width-1:0]      data_w1,
    input  logic                  en_w2_n,
    input  logic [addr_width-1:0] addr_w2,
    input  logic [width-1:0]      data_w2,
    input  logic                  en_r1_n,
    input  logic [addr_width-1:0] addr_r1,
    output logic [width-1:0]      data_r1,
    input  logic                  en_r2_n,
    input  logic [addr_width-1:0] addr_r2,
    output logic [width-1:0]      data_r2
);
    localparam int DEPTH = 2 ** addr_width;

    logic [width-1:0] mem_r [DEPTH];

    generate
        if (rst_mode == 0) begin : g_async
            // Storage array with asynchronous clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem_r[i] <= {width{1'b0}};
                end else begin
                    if (!en_w1_n) mem_r[addr_w1] <= data_w1;
                    if (!en_w2_n) mem_r[addr_w2] <= data_w2;
                end
            end
        end else begin : g_sync
            // Storage array with synchronous clear
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem_r[i] <= {width{1'b0}};
                end else begin
                    if (!en_w1_n) mem_r[addr_w1] <= data_w1;
                    if (!en_w2_n) mem_r[addr_w2] <= data_w2;
                end
            end
        end
    endgenerate

    assign data_r1 = en_r1_n ? {width{1'b0}} : mem_r[addr_r1];
    assign data_r2 = en_r2_n ? {width{1'b0}} : mem_r[addr_r2];

endmodule

// File: rtl/ram_2r_2w_rsp_reg.sv
// One-entry valid/ready holding register for a read response channel.
// Ports: clk, rst (async, active high), enable (controller in RUN),
//        req_valid/req_ready/accept (request side), load_data (RAM read word),
//        rsp_valid/rsp_ready/rsp_data (response side).
module ram_2r_2w_rsp_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             accept,
    input  logic [WIDTH-1:0] load_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);
    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // A new request fits when the slot is empty or is being drained this cycle.
    assign req_ready = enable & (~valid_r | rsp_ready);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = valid_r;
    assign rsp_data  = data_r;

    // Response slot: load on accept, clear on pop, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (accept) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (rsp_ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/ram_2r_2w_access_ctrl.sv
// Requester-side controller for a 2-read/2-write register-file RAM.
// After reset the RAM is cleared two words per cycle, then two write and two
// read valid/ready channels are mapped onto the RAM's active-low enables.
// Read data is captured into a per-port one-entry response register.
// Ports: clk, rst (async, active high), init_done,
//        w1_*/w2_* write channels (valid, ready, addr, data),
//        r1_*/r2_* read channels (req_valid, req_ready, req_addr,
//        rsp_valid, rsp_ready, rsp_data).
module ram_2r_2w_access_ctrl
    import ram_2r_2w_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  w1_valid,
    output logic                  w1_ready,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [WIDTH-1:0]      w1_data,
    input  logic                  w2_valid,
    output logic                  w2_ready,
    input  logic [ADDR_WIDTH-1:0] w2_addr,
    input  logic [WIDTH-1:0]      w2_data,
    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    output logic                  r1_rsp_valid,
    input  logic                  r1_rsp_ready,
    output logic [WIDTH-1:0]      r1_rsp_data,
    input  logic                  r2_req_valid,
    output logic                  r2_req_ready,
    input  logic [ADDR_WIDTH-1:0] r2_req_addr,
    output logic                  r2_rsp_valid,
    input  logic                  r2_rsp_ready,
    output logic [WIDTH-1:0]      r2_rsp_data
);
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(DEPTH - 2);

    ctrl_state_t           state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic                  init_done_r;

    logic                  run_s;
    logic                  w_collide_s;
    logic                  r1_accept_s;
    logic                  r2_accept_s;
    logic                  en_w1_n_s;
    logic                  en_w2_n_s;
    logic [ADDR_WIDTH-1:0] ram_addr_w1_s;
    logic [ADDR_WIDTH-1:0] ram_addr_w2_s;
    logic [WIDTH-1:0]      ram_data_w1_s;
    logic [WIDTH-1:0]      ram_data_w2_s;
    logic [WIDTH-1:0]      ram_data_r1_s;
    logic [WIDTH-1:0]      ram_data_r2_s;

    // Clear sequencer: two words per cycle, then RUN until the next reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= INIT;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    ptr_r <= ptr_r + ADDR_WIDTH'(2);
                    if (ptr_r == LAST_PAIR) begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= INIT;
                        init_done_r <= 1'b0;
                    end
                end
                RUN: begin
                    state_r     <= RUN;
                    ptr_r       <= ptr_r;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= INIT;
                    ptr_r       <= {ADDR_WIDTH{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign run_s     = (state_r == RUN);
    assign init_done = init_done_r;

    // Same-address writes: port 1 goes first, port 2 lands a cycle later and wins.
    assign w_collide_s = w1_valid & w2_valid &
                         addr_eq(ADDR_CMP_W'(w1_addr), ADDR_CMP_W'(w2_addr));
    assign w1_ready    = run_s;
    assign w2_ready    = run_s & ~w_collide_s;

    // RAM write port steering: clear pattern during INIT, client writes in RUN
    always_comb begin
        en_w1_n_s     = 1'b1;
        en_w2_n_s     = 1'b1;
        ram_addr_w1_s = w1_addr;
        ram_addr_w2_s = w2_addr;
        ram_data_w1_s = w1_data;
        ram_data_w2_s = w2_data;
        if (state_r == INIT) begin
            en_w1_n_s     = 1'b0;
            en_w2_n_s     = 1'b0;
            ram_addr_w1_s = ptr_r;
            ram_addr_w2_s = ptr_r + ADDR_WIDTH'(1);
            ram_data_w1_s = {WIDTH{1'b0}};
            ram_data_w2_s = {WIDTH{1'b0}};
        end else begin
            en_w1_n_s = ~(w1_valid & w1_ready);
            en_w2_n_s = ~(w2_valid & w2_ready);
        end
    end

    // Asynchronous RAM read is sampled at the same edge that commits writes,
    // which gives read-before-write ordering for same-cycle accesses.
    DW_ram_2r_2w_s_dff #(
        .width      (WIDTH),
        .addr_width (ADDR_WIDTH),
        .rst_mode   (0)
    ) u_ram (
        .clk     (clk),
        .rst_n   (~rst),
        .en_w1_n (en_w1_n_s),
        .addr_w1 (ram_addr_w1_s),
        .data_w1 (ram_data_w1_s),
        .en_w2_n (en_w2_n_s),
        .addr_w2 (ram_addr_w2_s),
        .data_w2 (ram_data_w2_s),
        .en_r1_n (~r1_accept_s),
        .addr_r1 (r1_req_addr),
        .data_r1 (ram_data_r1_s),
        .en_r2_n (~r2_accept_s),
        .addr_r2 (r2_req_addr),
        .data_r2 (ram_data_r2_s)
    );

    ram_2r_2w_rsp_reg #(.WIDTH(WIDTH)) u_rsp1 (
        .clk       (clk),
        .rst       (rst),
        .enable    (run_s),
        .req_valid (r1_req_valid),
        .req_ready (r1_req_ready),
        .accept    (r1_accept_s),
        .load_data (ram_data_r1_s),
        .rsp_valid (r1_rsp_valid),
        .rsp_ready (r1_rsp_ready),
        .rsp_data  (r1_rsp_data)
    );

    ram_2r_2w_rsp_reg #(.WIDTH(WIDTH)) u_rsp2 (
        .clk       (clk),
        .rst       (rst),
        .enable    (run_s),
        .req_valid (r2_req_valid),
        .req_ready (r2_req_ready),
        .accept    (r2_accept_s),
        .load_data (ram_data_r2_s),
        .rsp_valid (r2_rsp_valid),
        .rsp_ready (r2_rsp_ready),
        .rsp_data  (r2_rsp_data)
    );

endmodule

// File: tb/tb_ram_2r_2w_access_ctrl.sv
// Self-checking bench for ram_2r_2w_access_ctrl (WIDTH=8, ADDR_WIDTH=3).
// A reference memory model plus per-read-port queues of expected responses.
module tb_ram_2r_2w_access_ctrl;

    localparam int WIDTH = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_done;
    logic             w1_valid, w1_ready, w2_valid, w2_ready;
    logic [AW-1:0]    w1_addr, w2_addr;
    logic [WIDTH-1:0] w1_data, w2_data;
    logic             r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
    logic             r2_req_valid, r2_req_ready, r2_rsp_valid, r2_rsp_ready;
    logic [AW-1:0]    r1_req_addr, r2_req_addr;
    logic [WIDTH-1:0] r1_rsp_data, r2_rsp_data;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] q2 [$];
    int               pass_cnt  = 0;
    int               total_cnt = 0;

    always #5 clk = ~clk;

    ram_2r_2w_access_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .init_done    (init_done),
        .w1_valid     (w1_valid),
        .w1_ready     (w1_ready),
        .w1_addr      (w1_addr),
        .w1_data      (w1_data),
        .w2_valid     (w2_valid),
        .w2_ready     (w2_ready),
        .w2_addr      (w2_addr),
        .w2_data      (w2_data),
        .r1_req_valid (r1_req_valid),
        .r1_req_ready (r1_req_ready),
        .r1_req_addr  (r1_req_addr),
        .r1_rsp_valid (r1_rsp_valid),
        .r1_rsp_ready (r1_rsp_ready),
        .r1_rsp_data  (r1_rsp_data),
        .r2_req_valid (r2_req_valid),
        .r2_req_ready (r2_req_ready),
        .r2_req_addr  (r2_req_addr),
        .r2_rsp_valid (r2_rsp_valid),
        .r2_rsp_ready (r2_rsp_ready),
        .r2_rsp_data  (r2_rsp_data)
    );

    function automatic logic [WIDTH-1:0] pop_q1();
        if (q1.size() == 0) return 8'hxx;
        return q1.pop_front();
    endfunction

    function automatic logic [WIDTH-1:0] pop_q2();
        if (q2.size() == 0) return 8'hxx;
        return q2.pop_front();
    endfunction

    task automatic idle();
        w1_valid = 1'b0; w1_addr = '0; w1_data = '0;
        w2_valid = 1'b0; w2_addr = '0; w2_data = '0;
        r1_req_valid = 1'b0; r1_req_addr = '0; r1_rsp_ready = 1'b1;
        r2_req_valid = 1'b0; r2_req_addr = '0; r2_rsp_ready = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        q1.delete();
        q2.delete();
    endtask

    // Mid-cycle: record handshakes in the model (reads see pre-write data),
    // then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (r1_req_valid && r1_req_ready) q1.push_back(mem[r1_req_addr]);
        if (r2_req_valid && r2_req_ready) q2.push_back(mem[r2_req_addr]);
        if (w1_valid && w1_ready) mem[w1_addr] = w1_data;
        if (w2_valid && w2_ready) mem[w2_addr] = w2_data;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", init_done); else pass_cnt++;
        total_cnt++; if (w1_ready !== 1'b0 || w2_ready !== 1'b0) $display("FAIL reset_w_ready: got %b%b want 00", w1_ready, w2_ready); else pass_cnt++;
        total_cnt++; if (r1_req_ready !== 1'b0 || r2_req_ready !== 1'b0) $display("FAIL reset_r_ready: got %b%b want 00", r1_req_ready, r2_req_ready); else pass_cnt++;
        total_cnt++; if (r1_rsp_valid !== 1'b0 || r2_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b%b want 00", r1_rsp_valid, r2_rsp_valid); else pass_cnt++;
        total_cnt++; if (r1_rsp_data !== 8'h00 || r2_rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h %h want 00 00", r1_rsp_data, r2_rsp_data); else pass_cnt++;
        rst = 1'b0;
        r1_req_valid = 1'b1;
        #1;
        total_cnt++; if (r1_req_ready !== 1'b0) $display("FAIL init_no_ready: got %b want 0", r1_req_ready); else pass_cnt++;
        r1_req_valid = 1'b0;
        clear_model();
        wait_init(cycles);
        total_cnt++; if (cycles != 4) $display("FAIL init_latency: got %0d want 4 cycles", cycles); else pass_cnt++;
    endtask

    task automatic test_init_clear();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < DEPTH / 2; i++) begin
            r1_req_valid = 1'b1; r1_req_addr = AW'(2 * i);
            r2_req_valid = 1'b1; r2_req_addr = AW'(2 * i + 1);
            tick();
            exp = pop_q1();
            total_cnt++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== exp || exp !== 8'h00) $display("FAIL clear_r1 addr %0d: got v%b %h want v1 00", 2 * i, r1_rsp_valid, r1_rsp_data); else pass_cnt++;
            exp = pop_q2();
            total_cnt++; if (r2_rsp_valid !== 1'b1 || r2_rsp_data !== exp || exp !== 8'h00) $display("FAIL clear_r2 addr %0d: got v%b %h want v1 00", 2 * i + 1, r2_rsp_valid, r2_rsp_data); else pass_cnt++;
        end
        idle();
        tick();
        total_cnt++; if (r1_rsp_valid !== 1'b0) $display("FAIL clear_pop: got valid %b want 0", r1_rsp_valid); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [WIDTH-1:0] exp;
        w1_valid = 1'b1; w1_addr = 3'd3; w1_data = 8'hA5;
        tick();
        w1_valid = 1'b0;
        r1_req_valid = 1'b1; r1_req_addr = 3'd3;
        total_cnt++; if (r1_rsp_valid !== 1'b0) $display("FAIL wr_latency_pre: got valid %b want 0", r1_rsp_valid); else pass_cnt++;
        tick();
        r1_req_valid = 1'b0;
        exp = pop_q1();
        total_cnt++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== exp || exp !== 8'hA5) $display("FAIL wr_readback: got v%b %h want v1 a5", r1_rsp_valid, r1_rsp_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_collision();
        logic [WIDTH-1:0] exp;
        w1_valid = 1'b1; w1_addr = 3'd5; w1_data = 8'h11;
        w2_valid = 1'b1; w2_addr = 3'd5; w2_data = 8'h22;
        #1;
        total_cnt++; if (w1_ready !== 1'b1 || w2_ready !== 1'b0) $display("FAIL collide_ready: got w1 %b w2 %b want 1 0", w1_ready, w2_ready); else pass_cnt++;
        tick();
        w1_valid = 1'b0;
        #1;
        total_cnt++; if (w2_ready !== 1'b1) $display("FAIL collide_w2_retry: got %b want 1", w2_ready); else pass_cnt++;
        tick();
        w2_valid = 1'b0;
        r2_req_valid = 1'b1; r2_req_addr = 3'd5;
        tick();
        r2_req_valid = 1'b0;
        exp = pop_q2();
        total_cnt++; if (r2_rsp_valid !== 1'b1 || r2_rsp_data !== exp || exp !== 8'h22) $display("FAIL collide_readback: got v%b %h want v1 22", r2_rsp_valid, r2_rsp_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_read_before_write();
        logic [WIDTH-1:0] exp;
        r1_req_valid = 1'b1; r1_req_addr = 3'd2;
        w1_valid = 1'b1; w1_addr = 3'd2; w1_data = 8'h7E;
        tick();
        w1_valid = 1'b0;
        exp = pop_q1();
        total_cnt++; if (r1_rsp_data !== exp || exp !== 8'h00) $display("FAIL rbw_old: got %h want 00", r1_rsp_data); else pass_cnt++;
        tick();
        r1_req_valid = 1'b0;
        exp = pop_q1();
        total_cnt++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== exp || exp !== 8'h7E) $display("FAIL rbw_new: got v%b %h want v1 7e", r1_rsp_valid, r1_rsp_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [WIDTH-1:0] exp;
        r2_rsp_ready = 1'b0;
        r2_req_valid = 1'b1; r2_req_addr = 3'd3;
        tick();
        total_cnt++; if (r2_rsp_valid !== 1'b1 || r2_rsp_data !== 8'hA5) $display("FAIL bp_first: got v%b %h want v1 a5", r2_rsp_valid, r2_rsp_data); else pass_cnt++;
        r2_req_addr = 3'd5;
        r1_req_valid = 1'b1; r1_req_addr = 3'd5;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++; if (r2_req_ready !== 1'b0 || r1_req_ready !== 1'b1) $display("FAIL bp_ready cyc %0d: got r2 %b r1 %b want 0 1", i, r2_req_ready, r1_req_ready); else pass_cnt++;
            tick();
            total_cnt++; if (r2_rsp_valid !== 1'b1 || r2_rsp_data !== 8'hA5) $display("FAIL bp_hold cyc %0d: got v%b %h want v1 a5", i, r2_rsp_valid, r2_rsp_data); else pass_cnt++;
            exp = pop_q1();
            total_cnt++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== exp || exp !== 8'h22) $display("FAIL bp_r1 cyc %0d: got v%b %h want v1 22", i, r1_rsp_valid, r1_rsp_data); else pass_cnt++;
        end
        r1_req_valid = 1'b0;
        r2_req_valid = 1'b0;
        r2_rsp_ready = 1'b1;
        exp = pop_q2();
        total_cnt++; if (r2_rsp_data !== exp || q2.size() != 0) $display("FAIL bp_release: got %h want %h, extra %0d", r2_rsp_data, exp, q2.size()); else pass_cnt++;
        tick();
        total_cnt++; if (r2_rsp_valid !== 1'b0 || r2_rsp_data !== 8'hA5) $display("FAIL bp_drain: got v%b %h want v0 a5", r2_rsp_valid, r2_rsp_data); else pass_cnt++;
    endtask

    task automatic test_reset_mid_traffic();
        int cycles;
        w1_valid = 1'b1; w1_addr = 3'd6; w1_data = 8'h3C;
        tick();
        w1_valid = 1'b0;
        r1_rsp_ready = 1'b0;
        r1_req_valid = 1'b1; r1_req_addr = 3'd6;
        tick();
        total_cnt++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== 8'h3C) $display("FAIL mid_pending: got v%b %h want v1 3c", r1_rsp_valid, r1_rsp_data); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (r1_rsp_valid !== 1'b0 || init_done !== 1'b0) $display("FAIL mid_async: got valid %b init_done %b want 0 0", r1_rsp_valid, init_done); else pass_cnt++;
        idle();
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init(cycles);
        total_cnt++; if (cycles != 4) $display("FAIL mid_init_latency: got %0d want 4 cycles", cycles); else pass_cnt++;
        test_init_clear();
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_write_read();
        test_collision();
        test_read_before_write();
        test_back_pressure();
        test_reset_mid_traffic();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
